// File: rtl/cross_window_gen.sv
// -----------------------------------------------------------------------------
// cross_window_gen
// Streams an 8-bit raster image (row-major, column fastest) and produces the
// 5-pixel cross neighbourhood (north b, west d, centre e, east f, south h) for
// every interior pixel. Two COLS-deep line buffers hold the previous two rows.
// The window for centre (r-1,c-1) is formed when pixel (r,c) is accepted and
// appears on the outputs one cycle later behind a single-stage output register.
//
// Parameters:
//   COLS, ROWS      image width / height in pixels (each >= 3)
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   in_valid/in_ready/in_pixel    input pixel handshake
//   in_sof          start-of-frame marker (only with CROSS_WINDOW_SOF_EN)
//   out_valid/out_ready           window handshake
//   out_b/d/e/f/h   cross window (north, west, centre, east, south)
//   out_last        window belongs to the last interior centre of the frame
//
// Optional feature macro: CROSS_WINDOW_SOF_EN adds in_sof; an accepted pixel
// with in_sof=1 is taken as pixel (0,0) and the counters continue from there.
// -----------------------------------------------------------------------------
module cross_window_gen #(
  parameter int COLS = 512,
  parameter int ROWS = 512
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef CROSS_WINDOW_SOF_EN
  input  logic       in_sof,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pixel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_b,
  output logic [7:0] out_d,
  output logic [7:0] out_e,
  output logic [7:0] out_f,
  output logic [7:0] out_h,
  output logic       out_last
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;

  // Taps holding the previous one/two accepted columns.
  logic [7:0]      tap_h_q;   // (r,   c-1)
  logic [7:0]      tap_e_q;   // (r-1, c-1)
  logic [7:0]      tap_d_q;   // (r-1, c-2)
  logic [7:0]      tap_b_q;   // (r-2, c-1)

  logic            out_valid_q, out_last_q;
  logic [7:0]      out_b_q, out_d_q, out_e_q, out_f_q, out_h_q;

  logic [7:0]      lb1_mem [COLS];  // row r-1
  logic [7:0]      lb2_mem [COLS];  // row r-2

  logic            accept_s, sof_s, emit_s, last_s;
  logic [CW-1:0]   eff_col_s;
  logic [RW-1:0]   eff_row_s;
  logic [7:0]      rd1_s, rd2_s;

`ifdef CROSS_WINDOW_SOF_EN
  assign sof_s = in_sof;
`else
  assign sof_s = 1'b0;
`endif

  assign in_ready = !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;

  // A start-of-frame pixel is positioned at (0,0) whatever the counters say.
  assign eff_col_s = sof_s ? '0 : col_q;
  assign eff_row_s = sof_s ? '0 : row_q;

  assign rd1_s  = lb1_mem[eff_col_s];
  assign rd2_s  = lb2_mem[eff_col_s];
  assign emit_s = accept_s && !sof_s && (state_q == EMIT);
  assign last_s = (eff_row_s == ROW_LAST) && (eff_col_s == COL_LAST);

  // Next raster position and the FILL/EMIT decision for the next pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_s) begin
      if (eff_col_s == COL_LAST) begin
        col_d = '0;
        if (eff_row_s == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = eff_row_s + RW'(1);
        end
      end else begin
        col_d = eff_col_s + CW'(1);
        row_d = eff_row_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
    if ((row_d >= RW'(2)) && (col_d >= CW'(2))) begin
      state_d = EMIT;
    end else begin
      state_d = FILL;
    end
  end

  // Counters, FILL/EMIT state, column taps and the registered window output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      tap_h_q     <= 8'd0;
      tap_e_q     <= 8'd0;
      tap_d_q     <= 8'd0;
      tap_b_q     <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_b_q     <= 8'd0;
      out_d_q     <= 8'd0;
      out_e_q     <= 8'd0;
      out_f_q     <= 8'd0;
      out_h_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (accept_s) begin
        tap_h_q <= in_pixel;
        tap_e_q <= rd1_s;
        tap_d_q <= tap_e_q;
        tap_b_q <= rd2_s;
      end
      // A new window wins over consumption, so back-to-back windows keep
      // out_valid high.
      if (emit_s) begin
        out_valid_q <= 1'b1;
        out_last_q  <= last_s;
        out_b_q     <= tap_b_q;
        out_d_q     <= tap_d_q;
        out_e_q     <= tap_e_q;
        out_f_q     <= rd1_s;
        out_h_q     <= tap_h_q;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  // Line buffers: read-then-overwrite at the current column, no reset needed
  // because FILL never emits a window from unwritten entries.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb2_mem[eff_col_s] <= rd1_s;
      lb1_mem[eff_col_s] <= in_pixel;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_b     = out_b_q;
  assign out_d     = out_d_q;
  assign out_e     = out_e_q;
  assign out_f     = out_f_q;
  assign out_h     = out_h_q;

endmodule

// File: tb/tb_cross_window_gen.sv
module tb_cross_window_gen;
  localparam int C = 4;
  localparam int R = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_pixel = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_b, out_d, out_e, out_f, out_h;
  logic       out_last;
`ifdef CROSS_WINDOW_SOF_EN
  logic       in_sof = 1'b0;
`endif

  cross_window_gen #(.COLS(C), .ROWS(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CROSS_WINDOW_SOF_EN
    .in_sof    (in_sof),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_b     (out_b),
    .out_d     (out_d),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_h     (out_h),
    .out_last  (out_last)
  );

  typedef struct packed {
    logic [7:0] b, d, e, f, h;
    logic       last;
  } win_t;

  typedef struct packed {
    logic       v;
    logic [7:0] pix;
    logic       rdy;
    logic       exp_ir;
    logic       exp_ov;
    logic [7:0] exp_e;
  } vec_t;

  win_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_win = 0;
  int   n_last = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Expected windows of one frame whose pixel (r,c) is base+4r+c.
  task automatic push_frame(input logic [7:0] base);
    win_t w;
    for (int r = 1; r < R - 1; r++) begin
      for (int c = 1; c < C - 1; c++) begin
        w.b = base + 8'(4 * (r - 1) + c);
        w.d = base + 8'(4 * r + c - 1);
        w.e = base + 8'(4 * r + c);
        w.f = base + 8'(4 * r + c + 1);
        w.h = base + 8'(4 * (r + 1) + c);
        w.last = (r == R - 2) && (c == C - 2);
        exp_q.push_back(w);
      end
    end
  endtask

  // One clock: drive, score any window consumed at the coming edge, advance.
  task automatic step(input logic v, input logic [7:0] pix, input logic rdy,
                      output logic acc, output logic ir);
    win_t w;
    in_valid = v; in_pixel = pix; out_ready = rdy;
    #1;
    ir  = in_ready;
    acc = v && in_ready;
    if (out_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_window", 48'd1, 48'd0);
      end else begin
        w = exp_q.pop_front();
        check("window", {8'd0, out_b, out_d, out_e, out_f, out_h, out_last}, {8'd0, w});
      end
      n_win++;
      if (out_last) n_last++;
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pixel(input logic [7:0] p, input int vpct, input int rpct);
    logic acc, ir, v, rdy;
    int tries;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 200) begin
      v   = ($urandom_range(0, 99) < vpct);
      rdy = ($urandom_range(0, 99) < rpct);
      step(v, p, rdy, acc, ir);
      tries++;
    end
    if (!acc) check("accept_timeout", 48'd0, 48'd1);
  endtask

  task automatic send_frame(input logic [7:0] base, input int vpct, input int rpct);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        send_pixel(base + 8'(4 * r + c), vpct, rpct);
  endtask

  task automatic drain();
    logic acc, ir;
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b1, acc, ir);
    check("queue_empty", 48'(exp_q.size()), 48'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", {47'd0, out_valid}, 48'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    n_win = 0; n_last = 0;
  endtask

  initial begin
    vec_t tbl[15];
    logic acc, ir;

    // Stall table: first window appears after pixel 10, then held for 3 cycles.
    for (int i = 0; i <= 10; i++)
      tbl[i] = '{v: 1'b1, pix: 8'(i), rdy: 1'b1, exp_ir: 1'b1,
                 exp_ov: (i == 10), exp_e: (i == 10) ? 8'd5 : 8'd0};
    for (int i = 11; i <= 13; i++)
      tbl[i] = '{v: 1'b1, pix: 8'd11, rdy: 1'b0, exp_ir: 1'b0, exp_ov: 1'b1, exp_e: 8'd5};
    tbl[14] = '{v: 1'b1, pix: 8'd11, rdy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b1, exp_e: 8'd6};

    // Reset state
    do_reset();
    check("reset_in_ready", {47'd0, in_ready}, 48'd1);
    check("reset_out_last", {47'd0, out_last}, 48'd0);
    check("reset_out_e", {40'd0, out_e}, 48'd0);
    check("reset_out_b", {40'd0, out_b}, 48'd0);

    // Single frame with a backpressure stall on the first window
    push_frame(8'd0);
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].pix, tbl[i].rdy, acc, ir);
      check("tbl_in_ready", {47'd0, ir}, {47'd0, tbl[i].exp_ir});
      check("tbl_out_valid", {47'd0, out_valid}, {47'd0, tbl[i].exp_ov});
      check("tbl_out_e", {40'd0, out_e}, {40'd0, tbl[i].exp_e});
    end
    for (int p = 12; p < 16; p++) send_pixel(8'(p), 100, 100);
    drain();
    check("frame1_windows", 48'(n_win), 48'd4);
    check("frame1_lasts", 48'(n_last), 48'd1);

    // Two back-to-back frames, continuous valid
    do_reset();
    push_frame(8'd0); push_frame(8'd0);
    send_frame(8'd0, 100, 100);
    send_frame(8'd0, 100, 100);
    drain();
    check("b2b_windows", 48'(n_win), 48'd8);
    check("b2b_lasts", 48'(n_last), 48'd2);

    // Reset after 7 pixels, then a full frame
    do_reset();
    for (int p = 0; p < 7; p++) send_pixel(8'(p), 100, 100);
    do_reset();
    push_frame(8'd0);
    send_frame(8'd0, 100, 100);
    drain();
    check("rst7_windows", 48'(n_win), 48'd4);

    // Reset while a window is pending in the output register
    do_reset();
    for (int p = 0; p < 11; p++) send_pixel(8'(p), 100, 100);
    check("pending_valid", {47'd0, out_valid}, 48'd1);
    do_reset();
    check("pending_dropped", {47'd0, out_valid}, 48'd0);
    push_frame(8'd40);
    send_frame(8'd40, 100, 100);
    drain();
    check("pending_windows", 48'(n_win), 48'd4);

    // Random valid/ready over several frames
    do_reset();
    for (int k = 0; k < 6; k++) push_frame(8'(16 * k));
    for (int k = 0; k < 6; k++) send_frame(8'(16 * k), 50, 70);
    drain();
    check("rand_windows", 48'(n_win), 48'd24);
    check("rand_lasts", 48'(n_last), 48'd6);

`ifdef CROSS_WINDOW_SOF_EN
    // Start-of-frame resynchronisation after a partial frame
    do_reset();
    for (int p = 0; p < 5; p++) send_pixel(8'(p + 100), 100, 100);
    push_frame(8'd0);
    in_sof = 1'b1;
    send_pixel(8'd0, 100, 100);
    in_sof = 1'b0;
    for (int p = 1; p < 16; p++) send_pixel(8'(p), 100, 100);
    drain();
    check("sof_windows", 48'(n_win), 48'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
